// File: rtl/madd_pkg.sv
// Shared types and constants for the chain-MADD result collector.
package madd_pkg;

    localparam int unsigned RESULT_W             = 32;
    localparam int unsigned MADD_LATENCY_DEFAULT = 4;

    // One completed dot product as stored in the output FIFO.
    typedef struct packed {
        logic                ovf;
        logic [RESULT_W-1:0] data;
    } fifo_entry_t;

    // Two's-complement add overflow from the operand and sum sign bits.
    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/madd_result_collector_if.sv
// Operand-side and result-side handshake bundle of the result collector.
interface madd_result_collector_if #(
    parameter int unsigned RESULT_W = madd_pkg::RESULT_W
);
    logic                in_valid;
    logic                in_last;
    logic                in_ready;
    logic [RESULT_W-1:0] madd_result;
    logic                out_valid;
    logic                out_ready;
    logic [RESULT_W-1:0] out_data;
    logic                out_ovf;

    // Environment side: upstream MADD feeder plus downstream consumer.
    modport master (
        output in_valid, in_last, madd_result, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    // Collector side.
    modport slave (
        input  in_valid, in_last, madd_result, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/madd_result_fifo.sv
// Output FIFO for completed dot products; caller respects full/empty.
module madd_result_fifo
    import madd_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  fifo_entry_t      wdata,
    input  logic             pop,
    output fifo_entry_t      head_c,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fifo_entry_t      mem [DEPTH];
    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] wr_next;
    logic [CNT_W-1:0] rd_next;

    // Next pointers; the top bit is the lap flag that separates full from empty.
    always_comb begin
        wr_next = wr_ptr;
        rd_next = rd_ptr;
        if (push) wr_next = wr_ptr + CNT_W'(1);
        if (pop)  rd_next = rd_ptr + CNT_W'(1);
    end

    // Pointers, occupancy and flags, all registered from the next pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            count  <= wr_next - rd_next;
            full   <= (wr_next == {~rd_next[CNT_W-1], rd_next[CNT_W-2:0]});
            empty  <= (wr_next == rd_next);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
    end

    // Head entry, forced to zero when nothing is buffered.
    always_comb begin
        head_c = '0;
        if (!empty) head_c = mem[rd_ptr[PTR_W-1:0]];
    end

endmodule

// File: rtl/madd_result_collector.sv
// Tracks beats through the chain MADD, accumulates per dot product and
// buffers completed sums with an overflow flag.
module madd_result_collector #(
    parameter int unsigned MADD_LATENCY = madd_pkg::MADD_LATENCY_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned RESULT_W     = madd_pkg::RESULT_W
) (
    input logic                    clock,
    input logic                    reset,
    madd_result_collector_if.slave bus
);
    import madd_pkg::*;

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [MADD_LATENCY-1:0] vld_pipe;
    logic [MADD_LATENCY-1:0] lst_pipe;
    logic [RESULT_W-1:0]     acc_q;
    logic                    ovf_q;
    logic [CNT_W-1:0]        lif_q;
    logic                    in_ready_q;

    logic                    accept;
    logic                    accept_last;
    logic                    tail_valid;
    logic                    tail_last;
    logic [RESULT_W-1:0]     sum;
    logic                    add_ovf;
    logic                    push;
    logic                    pop;
    logic [CNT_W-1:0]        lif_next;
    logic [SUM_W-1:0]        reserve_next;
    fifo_entry_t             push_entry;

    fifo_entry_t             head;
    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Handshake decode, accumulate datapath and FIFO-slot reservation.
    always_comb begin
        accept          = bus.in_valid && in_ready_q;
        accept_last     = accept && bus.in_last;
        tail_valid      = vld_pipe[MADD_LATENCY-1];
        tail_last       = lst_pipe[MADD_LATENCY-1];
        sum             = acc_q + bus.madd_result;
        add_ovf         = add_overflow(acc_q[RESULT_W-1], bus.madd_result[RESULT_W-1],
                                       sum[RESULT_W-1]);
        pop             = bus.out_ready && !fifo_empty;
        push            = tail_valid && tail_last && (!fifo_full || pop);
        push_entry.ovf  = ovf_q | add_ovf;
        push_entry.data = sum;
        lif_next        = lif_q;
        if (accept_last && !push)      lif_next = lif_q + CNT_W'(1);
        else if (!accept_last && push) lif_next = lif_q - CNT_W'(1);
        // A last in flight already owns a FIFO slot, so count it against depth.
        reserve_next    = SUM_W'(fifo_count) + SUM_W'(lif_q) + SUM_W'(accept_last)
                          - SUM_W'(pop);
    end

    // Beat flags travel alongside the MADD so the tail lines up with madd_result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            lst_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            lst_pipe[0] <= accept_last;
            for (int i = 1; i < int'(MADD_LATENCY); i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                lst_pipe[i] <= lst_pipe[i-1];
            end
        end
    end

    // Running sum and sticky overflow; a last beat closes out and clears them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (tail_valid) begin
            if (tail_last) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= sum;
                ovf_q <= ovf_q | add_ovf;
            end
        end
    end

    // Lasts-in-flight count and registered ready derived from next-cycle reservation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lif_q      <= '0;
            in_ready_q <= 1'b0;
        end else begin
            lif_q      <= lif_next;
            in_ready_q <= (reserve_next < SUM_W'(FIFO_DEPTH));
        end
    end

    madd_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .wdata  (push_entry),
        .pop    (pop),
        .head_c (head),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head.data;
    assign bus.out_ovf   = head.ovf;

endmodule

// File: tb/tb_madd_result_collector.sv
// Directed bench for madd_result_collector with a behavioural chain-MADD source.
module tb_madd_result_collector;

    localparam int unsigned L           = 4;
    localparam int unsigned DEPTH       = 8;
    localparam logic [31:0] IDLE_RESULT = 32'd999;

    logic clock = 1'b0;
    logic reset;
    logic [31:0] beat_val;
    logic [31:0] mpipe [L];
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    madd_result_collector_if #(.RESULT_W(32)) m ();

    madd_result_collector #(
        .MADD_LATENCY (L),
        .FIFO_DEPTH   (DEPTH),
        .RESULT_W     (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (m)
    );

    // Chain MADD stand-in: accepted beats emerge L cycles later, junk otherwise.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < L; i++) mpipe[i] <= IDLE_RESULT;
        end else begin
            mpipe[0] <= (m.in_valid && m.in_ready) ? beat_val : IDLE_RESULT;
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign m.madd_result = mpipe[L-1];

    // Record every output transfer.
    always @(posedge clock) begin
        if (!reset && m.out_valid && m.out_ready) got_q.push_back({m.out_ovf, m.out_data});
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "/count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s/%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Present a beat at a falling edge and hold it until ready is seen.
    task automatic send(input logic [31:0] v, input logic last);
        int waited;
        waited = 0;
        @(negedge clock);
        m.in_valid = 1'b1;
        m.in_last  = last;
        beat_val   = v;
        while (!m.in_ready && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (!m.in_ready) check_eq("send_ready", 64'(m.in_ready), 64'd1);
    endtask

    task automatic idle();
        @(negedge clock);
        m.in_valid = 1'b0;
        m.in_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        reset       = 1'b1;
        m.in_valid  = 1'b0;
        m.in_last   = 1'b0;
        m.out_ready = 1'b0;
        beat_val    = '0;

        // Reset values, then ready one cycle after release.
        repeat (3) @(negedge clock);
        check_eq("rst_out_valid", 64'(m.out_valid), 64'd0);
        check_eq("rst_out_data",  64'(m.out_data),  64'd0);
        check_eq("rst_out_ovf",   64'(m.out_ovf),   64'd0);
        check_eq("rst_in_ready",  64'(m.in_ready),  64'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("post_rst_in_ready", 64'(m.in_ready), 64'd1);

        // 3-beat product 10 + -4 + 100 with exact output latency.
        m.out_ready = 1'b1;
        send(32'd10, 1'b0);
        send(32'hFFFF_FFFC, 1'b0);
        send(32'd100, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i == 1) begin
                m.in_valid = 1'b0;
                m.in_last  = 1'b0;
            end
            check_eq($sformatf("lat_valid_t%0d", i), 64'(m.out_valid), 64'(i == 5));
        end
        check_eq("dot3_data", 64'(m.out_data), 64'd106);
        check_eq("dot3_ovf",  64'(m.out_ovf),  64'd0);
        exp_q.push_back({1'b0, 32'd106});
        repeat (3) @(negedge clock);
        check_outputs("dot3");

        // Overflow cases: positive wrap, clean single beat, sticky flag, negative wrap.
        send(32'h7FFF_FFFF, 1'b0);
        send(32'd1, 1'b1);
        send(32'd5, 1'b1);
        send(32'h7FFF_FFFF, 1'b0);
        send(32'd1, 1'b0);
        send(32'd0, 1'b1);
        send(32'h8000_0000, 1'b0);
        send(32'hFFFF_FFFF, 1'b1);
        idle();
        repeat (10) @(negedge clock);
        exp_q.push_back({1'b1, 32'h8000_0000});
        exp_q.push_back({1'b0, 32'd5});
        exp_q.push_back({1'b1, 32'h8000_0000});
        exp_q.push_back({1'b1, 32'h7FFF_FFFF});
        check_outputs("ovf");

        // Back-pressure: continuous single beats, blocked beats carry 999.
        m.out_ready = 1'b0;
        accepted    = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            m.in_valid = 1'b1;
            m.in_last  = 1'b1;
            if (m.in_ready) begin
                beat_val = 32'(k + 1);
                accepted++;
            end else begin
                beat_val = IDLE_RESULT;
            end
        end
        @(negedge clock);
        m.in_valid = 1'b0;
        m.in_last  = 1'b0;
        check_eq("bp_accepted",  64'(accepted),    64'd8);
        check_eq("bp_in_ready",  64'(m.in_ready),  64'd0);
        check_eq("bp_out_valid", 64'(m.out_valid), 64'd1);
        check_eq("bp_head_hold", 64'(m.out_data),  64'd1);
        m.out_ready = 1'b1;
        repeat (14) @(negedge clock);
        for (int k = 1; k <= 8; k++) exp_q.push_back({1'b0, 32'(k)});
        check_outputs("bp");
        check_eq("bp_drained_valid", 64'(m.out_valid), 64'd0);
        check_eq("bp_drained_ready", 64'(m.in_ready),  64'd1);

        // Seven buffered entries, then a push and pop in the same cycle.
        m.out_ready = 1'b0;
        for (int v = 21; v <= 27; v++) send(32'(v), 1'b1);
        idle();
        repeat (8) @(negedge clock);
        check_eq("pp_head_before", 64'(m.out_data), 64'd21);
        send(32'd28, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            if (i == 1) begin
                m.in_valid = 1'b0;
                m.in_last  = 1'b0;
            end
            if (i == 2) check_eq("pp_ready_low", 64'(m.in_ready), 64'd0);
            if (i == 4) m.out_ready = 1'b1;
            if (i == 5) m.out_ready = 1'b0;
        end
        check_eq("pp_count",      64'(dut.u_fifo.count), 64'd7);
        check_eq("pp_ready_back", 64'(m.in_ready),       64'd1);
        check_eq("pp_head_after", 64'(m.out_data),       64'd22);
        m.out_ready = 1'b1;
        repeat (12) @(negedge clock);
        for (int v = 21; v <= 28; v++) exp_q.push_back({1'b0, 32'(v)});
        check_outputs("pp");

        // Reset with three entries buffered and two lasts in flight.
        m.out_ready = 1'b0;
        for (int v = 31; v <= 33; v++) send(32'(v), 1'b1);
        idle();
        repeat (7) @(negedge clock);
        send(32'd34, 1'b1);
        send(32'd35, 1'b1);
        @(negedge clock);
        m.in_valid = 1'b0;
        m.in_last  = 1'b0;
        check_eq("mid_rst_pre_valid", 64'(m.out_valid), 64'd1);
        check_eq("mid_rst_pre_head",  64'(m.out_data),  64'd31);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", 64'(m.out_valid), 64'd0);
        check_eq("mid_rst_out_data",  64'(m.out_data),  64'd0);
        check_eq("mid_rst_in_ready",  64'(m.in_ready),  64'd0);
        repeat (2) @(negedge clock);
        reset       = 1'b0;
        m.out_ready = 1'b1;
        repeat (15) @(negedge clock);
        check_outputs("mid_rst");
        check_eq("mid_rst_idle_valid", 64'(m.out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/madd_result_collector.md
MADD_RESULT_COLLECTOR -- requirements
Module: madd_result_collector

Interface
REQ-001 SHALL take parameter MADD_LATENCY, default 4: cycles from operand issue to a valid 32-bit chain-MADD result.
REQ-002 SHALL take parameter FIFO_DEPTH, default 8: output FIFO entries; a power of two, at least 2.
REQ-003 SHALL take parameter RESULT_W, default 32: width of the MADD result and of the accumulator.
REQ-004 SHALL have port: clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port: in_valid  in  1  an operand beat is presented to the chain MADD this cycle.
REQ-007 SHALL have port: in_last  in  1  marks the final beat of one dot product; qualified by in_valid.
REQ-008 SHALL have port: in_ready  out  1  the collector accepts the beat this cycle.
REQ-009 SHALL have port: madd_result  in  RESULT_W  signed result from the chain MADD.
REQ-010 SHALL have port: out_valid  out  1  a completed dot product is available.
REQ-011 SHALL have port: out_ready  in  1  downstream accepts the output this cycle.
REQ-012 SHALL have port: out_data  out  RESULT_W  completed signed dot-product sum.
REQ-013 SHALL have port: out_ovf  out  1  signed overflow occurred during out_data accumulation.

Function
REQ-014 SHALL define an accepted beat as in_valid AND in_ready in the same cycle; a beat with in_ready low SHALL be untracked, and the upstream SHALL hold it.
REQ-015 SHALL carry each accepted beat's valid and last flags through a MADD_LATENCY-stage delay line; the flags SHALL reach the tail exactly when madd_result for that beat is valid.
REQ-016 SHALL update the accumulator on a tail-valid beat that is not last: acc <= acc + madd_result, wrapping at RESULT_W; ovf_sticky <= ovf_sticky OR signed overflow of that add.
REQ-017 SHALL handle a tail-valid beat that is last as follows: push {acc + madd_result, ovf_sticky OR its overflow} into the FIFO, then clear acc and ovf_sticky to 0 in the same cycle.
REQ-018 SHALL ignore madd_result whenever the tail flag is invalid.
REQ-019 SHALL give latency: a last beat accepted in cycle T produces out_valid high in cycle T+MADD_LATENCY+1 when the FIFO was empty.
REQ-020 SHALL drive in_ready = (fifo_count + lasts_in_flight) < FIFO_DEPTH, where lasts_in_flight counts last flags held in the delay line; this SHALL guarantee the FIFO never overflows.
REQ-021 SHALL make out_valid equal to FIFO not empty, with out_data and out_ovf showing the head entry; a pop SHALL occur on out_valid AND out_ready.
REQ-022 SHALL keep out_data and out_ovf stable while out_valid is high and out_ready is low.
REQ-023 SHALL allow a push and a pop in the same cycle at any occupancy, leaving the count unchanged.
REQ-024 SHALL have no effect when out_ready is asserted with the FIFO empty.
REQ-025 SHALL treat a single-beat dot product (in_last on the first beat) as madd_result alone.
REQ-026 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, using an extra bit to distinguish full from empty.

Reset
REQ-027 SHALL, while reset is high, clear the delay line, acc, ovf_sticky, FIFO pointers and fifo_count immediately.
REQ-028 SHALL hold these output values in reset: out_valid=0, out_data=0, out_ovf=0, in_ready=0.
REQ-029 SHALL raise in_ready in the first cycle after reset deasserts.
REQ-030 SHALL discard all in-flight and buffered results when reset is asserted mid-operation, with none emitted afterward.

Structure
REQ-031 SHALL place RESULT_W, the MADD_LATENCY default and the FIFO entry typedef {ovf, data} in the shared package madd_pkg.
REQ-032 SHALL implement the FIFO as sub-module madd_result_fifo: synchronous, registered memory, exposing count, full and empty.

Verification
REQ-033 SHALL cover: 3-beat product with results 10, -4, 100, out_ready=1 -> one output 106, out_ovf=0, at T_last+5.
REQ-034 SHALL cover: 2-beat product with results 0x7FFFFFFF, 1 -> out_data 0x80000000, out_ovf=1; the next product 5 (1 beat) -> 5, out_ovf=0.
REQ-035 SHALL cover: out_ready=0 with continuous single-beat products -> in_ready falls after exactly 8 accepted lasts, and nothing is lost or duplicated when out_ready is then released.
REQ-036 SHALL cover: in_valid=1 with in_ready=0 while madd_result=999 -> no accumulation, no output.
REQ-037 SHALL cover: reset asserted with 2 lasts in the delay line and 3 FIFO entries -> out_valid=0 immediately, and no outputs after release.
REQ-038 SHALL cover: FIFO at 7 entries with a simultaneous push and pop -> count stays 7, and output order is preserved.
